// File: rtl/pong_pkg.sv
// Shared definitions for the button conditioner.
// Contents:
//   Def*           default timing constants (25 MHz board clock)
//   btn_state_t    per-channel debounce FSM state encoding
//   cnt_width()    width of a counter that must reach a given terminal count
package pong_pkg;

    localparam int unsigned DefNumBtn         = 4;
    localparam int unsigned DefDebounceCycles = 250000;    // 10 ms at 25 MHz
    localparam int unsigned DefRepeatDelay    = 12500000;  // 500 ms at 25 MHz
    localparam int unsigned DefRepeatPeriod   = 2500000;   // 100 ms at 25 MHz

    typedef logic [1:0] btn_state_t;

    localparam btn_state_t StIdle        = 2'd0;
    localparam btn_state_t StPressWait   = 2'd1;
    localparam btn_state_t StHeld        = 2'd2;
    localparam btn_state_t StReleaseWait = 2'd3;

    // One spare bit over $clog2 so the terminal value always fits.
    function automatic int unsigned cnt_width(input int unsigned n);
        return $clog2(n) + 1;
    endfunction

endpackage

// File: rtl/button_conditioner_if.sv
// Button bundle between the board-side driver and the conditioner.
// Signals (all NUM_BTN wide, one bit per button):
//   btn_n        raw active-low buttons
//   btn_level    debounced level, 1 = pressed
//   btn_press    one-cycle pulse on accepted press
//   btn_release  one-cycle pulse on accepted release
//   btn_repeat   one-cycle auto-repeat pulse while held
// Modports: master drives btn_n, slave (the conditioner) drives the rest.
interface button_conditioner_if #(
    parameter int unsigned NUM_BTN = pong_pkg::DefNumBtn
);

    logic [NUM_BTN-1:0] btn_n;
    logic [NUM_BTN-1:0] btn_level;
    logic [NUM_BTN-1:0] btn_press;
    logic [NUM_BTN-1:0] btn_release;
    logic [NUM_BTN-1:0] btn_repeat;

    modport master (
        output btn_n,
        input  btn_level,
        input  btn_press,
        input  btn_release,
        input  btn_repeat
    );

    modport slave (
        input  btn_n,
        output btn_level,
        output btn_press,
        output btn_release,
        output btn_repeat
    );

endinterface

// File: rtl/debounce_channel.sv
// Single-button conditioner: 2-flop synchronizer, debounce FSM, auto-repeat.
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   btn_n         raw active-low button
//   btn_level     registered debounced level (1 = pressed)
//   btn_press     registered one-cycle pulse on accepted press
//   btn_release   registered one-cycle pulse on accepted release
//   btn_repeat    registered one-cycle auto-repeat pulse while held
module debounce_channel
    import pong_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DefDebounceCycles,
    parameter int unsigned REPEAT_DELAY    = DefRepeatDelay,
    parameter int unsigned REPEAT_PERIOD   = DefRepeatPeriod
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_n,
    output logic btn_level,
    output logic btn_press,
    output logic btn_release,
    output logic btn_repeat
);

    localparam int unsigned CntW   = cnt_width(DEBOUNCE_CYCLES);
    localparam int unsigned RepMax = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY
                                                                    : REPEAT_PERIOD;
    localparam int unsigned RcntW  = cnt_width(RepMax);
    localparam bit          RepeatEn = (REPEAT_DELAY != 0);

    localparam logic [CntW-1:0]  CntLast    = CntW'(DEBOUNCE_CYCLES - 1);
    localparam logic [RcntW-1:0] DelayLast  = RcntW'(RepeatEn ? REPEAT_DELAY - 1 : 0);
    localparam logic [RcntW-1:0] PeriodLast = RcntW'(REPEAT_PERIOD - 1);
    localparam logic [RcntW-1:0] RcntMax    = '1;

    logic             sync1_q, sync2_q;
    btn_state_t       state_q, state_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic [RcntW-1:0] rcnt_q, rcnt_d;
    // Set until the first repeat of a hold has fired: selects DELAY vs PERIOD.
    logic             rep_first_q, rep_first_d;
    logic             level_q, level_d;
    logic             press_q, press_d;
    logic             release_q, release_d;
    logic             repeat_q, repeat_d;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rcnt_d      = rcnt_q;
        rep_first_d = rep_first_q;
        level_d     = level_q;
        press_d     = 1'b0;
        release_d   = 1'b0;
        repeat_d    = 1'b0;

        case (state_q)
            StIdle: begin
                if (!sync2_q) begin
                    state_d = StPressWait;
                    cnt_d   = '0;
                end
            end
            StPressWait: begin
                if (sync2_q) begin
                    state_d = StIdle;
                end else if (cnt_q == CntLast) begin
                    state_d     = StHeld;
                    level_d     = 1'b1;
                    press_d     = 1'b1;
                    rcnt_d      = '0;
                    rep_first_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StHeld: begin
                if (sync2_q) begin
                    state_d = StReleaseWait;
                    cnt_d   = '0;
                end else if (RepeatEn) begin
                    if (( rep_first_q && rcnt_q == DelayLast) ||
                        (!rep_first_q && rcnt_q == PeriodLast)) begin
                        repeat_d    = 1'b1;
                        rcnt_d      = '0;
                        rep_first_d = 1'b0;
                    end else if (rcnt_q != RcntMax) begin
                        rcnt_d = rcnt_q + 1'b1;
                    end
                end
            end
            StReleaseWait: begin
                // rcnt deliberately untouched: a release glitch resumes the repeat cadence.
                if (!sync2_q) begin
                    state_d = StHeld;
                end else if (cnt_q == CntLast) begin
                    state_d   = StIdle;
                    level_d   = 1'b0;
                    release_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q     <= 1'b1;
            sync2_q     <= 1'b1;
            state_q     <= StIdle;
            cnt_q       <= '0;
            rcnt_q      <= '0;
            rep_first_q <= 1'b0;
            level_q     <= 1'b0;
            press_q     <= 1'b0;
            release_q   <= 1'b0;
            repeat_q    <= 1'b0;
        end else begin
            sync1_q     <= btn_n;
            sync2_q     <= sync1_q;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rcnt_q      <= rcnt_d;
            rep_first_q <= rep_first_d;
            level_q     <= level_d;
            press_q     <= press_d;
            release_q   <= release_d;
            repeat_q    <= repeat_d;
        end
    end

    assign btn_level   = level_q;
    assign btn_press   = press_q;
    assign btn_release = release_q;
    assign btn_repeat  = repeat_q;

endmodule

// File: rtl/button_conditioner.sv
// Multi-button conditioner: one independent debounce_channel per button.
// Ports:
//   clk, rst   clock, asynchronous active-high reset
//   bus        button bundle (slave side): btn_n in; level/press/release/repeat out
// Bit mapping: 0 = up, 1 = down, 2 = pause, 3 = switchPlayer.
module button_conditioner
    import pong_pkg::*;
#(
    parameter int unsigned NUM_BTN         = DefNumBtn,
    parameter int unsigned DEBOUNCE_CYCLES = DefDebounceCycles,
    parameter int unsigned REPEAT_DELAY    = DefRepeatDelay,
    parameter int unsigned REPEAT_PERIOD   = DefRepeatPeriod
) (
    input  logic                 clk,
    input  logic                 rst,
    button_conditioner_if.slave  bus
);

    logic [NUM_BTN-1:0] level_w;
    logic [NUM_BTN-1:0] press_w;
    logic [NUM_BTN-1:0] release_w;
    logic [NUM_BTN-1:0] repeat_w;

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_chan
        debounce_channel #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .REPEAT_DELAY    (REPEAT_DELAY),
            .REPEAT_PERIOD   (REPEAT_PERIOD)
        ) u_chan (
            .clk         (clk),
            .rst         (rst),
            .btn_n       (bus.btn_n[i]),
            .btn_level   (level_w[i]),
            .btn_press   (press_w[i]),
            .btn_release (release_w[i]),
            .btn_repeat  (repeat_w[i])
        );
    end

    assign bus.btn_level   = level_w;
    assign bus.btn_press   = press_w;
    assign bus.btn_release = release_w;
    assign bus.btn_repeat  = repeat_w;

endmodule

// File: tb/tb_button_conditioner.sv
// Self-checking bench for button_conditioner with DEBOUNCE_CYCLES=4,
// REPEAT_DELAY=6, REPEAT_PERIOD=3. Every expected pulse is queued with the
// edge number it must appear after; a negedge monitor pops and compares.
module tb_button_conditioner;

    localparam int NB = 4;
    localparam int KPress   = 0;
    localparam int KRelease = 1;
    localparam int KRepeat  = 2;
    localparam int Lat      = 7;   // DEBOUNCE_CYCLES + 3

    typedef struct {
        int edge_n;
        int kind;
        int bit_n;
    } ev_t;

    logic clk;
    logic rst;
    logic [NB-1:0] btn_n_tb;
    int edge_cnt = 0;
    int checks = 0;
    int errors = 0;
    ev_t exp_q[$];

    button_conditioner_if #(.NUM_BTN(NB)) bus ();
    assign bus.btn_n = btn_n_tb;

    button_conditioner #(
        .NUM_BTN         (NB),
        .DEBOUNCE_CYCLES (4),
        .REPEAT_DELAY    (6),
        .REPEAT_PERIOD   (3)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    // Pulse monitor: every observed pulse must match the head of the queue.
    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            for (int b = 0; b < NB; b++) begin
                logic v;
                ev_t e;
                v = (k == KPress) ? bus.btn_press[b] :
                    (k == KRelease) ? bus.btn_release[b] : bus.btn_repeat[b];
                if (v === 1'b1) begin
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_pulse: kind %0d bit %0d after edge %0d, none expected",
                                 k, b, edge_cnt);
                    end else begin
                        e = exp_q.pop_front();
                        if (e.edge_n !== edge_cnt || e.kind !== k || e.bit_n !== b) begin
                            errors++;
                            $display("FAIL pulse_match: got kind %0d bit %0d edge %0d, want kind %0d bit %0d edge %0d",
                                     k, b, edge_cnt, e.kind, e.bit_n, e.edge_n);
                        end
                    end
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(negedge clk);
    endtask

    task automatic push_ev(input int e, input int k, input int b);
        ev_t ev;
        ev.edge_n = e;
        ev.kind   = k;
        ev.bit_n  = b;
        exp_q.push_back(ev);
    endtask

    task automatic drain(input string name);
        int w = 0;
        while (exp_q.size() != 0 && w < 40) begin
            step();
            w++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s_drain: %0d expected pulses missing, first due after edge %0d",
                     name, exp_q.size(), exp_q[0].edge_n);
            exp_q.delete();
        end
        repeat (3) step();
    endtask

    task automatic check_level(input string name, input logic [NB-1:0] want);
        checks++;
        if (bus.btn_level !== want) begin
            errors++;
            $display("FAIL %s_level: after edge %0d got %b want %b",
                     name, edge_cnt, bus.btn_level, want);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        btn_n_tb = '1;
        repeat (3) begin
            step();
            checks++;
            if ({bus.btn_level, bus.btn_press, bus.btn_release, bus.btn_repeat} !== '0) begin
                errors++;
                $display("FAIL reset_outputs: got %h want 0",
                         {bus.btn_level, bus.btn_press, bus.btn_release, bus.btn_repeat});
            end
        end
        rst = 1'b0;
        repeat (4) begin
            step();
            check_level("reset_idle", '0);
        end
    endtask

    task automatic test_clean_press();
        int n, m;
        step();
        n = edge_cnt;
        btn_n_tb[0] = 1'b0;
        push_ev(n + Lat, KPress, 0);
        for (int i = 0; i < 8; i++) begin
            step();
            check_level("clean_press", {3'b000, (edge_cnt >= n + Lat)});
        end
        m = edge_cnt;
        btn_n_tb[0] = 1'b1;
        push_ev(m + Lat, KRelease, 0);
        for (int i = 0; i < 9; i++) begin
            step();
            check_level("clean_release", {3'b000, (edge_cnt < m + Lat)});
        end
        drain("clean_press");
    endtask

    task automatic test_bounce();
        step();
        btn_n_tb[1] = 1'b0;
        repeat (3) step();
        btn_n_tb[1] = 1'b1;
        for (int i = 0; i < 12; i++) begin
            step();
            check_level("bounce", '0);
        end
        drain("bounce");
    endtask

    task automatic test_repeat();
        int n, m;
        step();
        n = edge_cnt;
        btn_n_tb[0] = 1'b0;
        push_ev(n + Lat, KPress, 0);
        for (int off = 6; off <= 18; off += 3) push_ev(n + Lat + off, KRepeat, 0);
        while (edge_cnt < n + 24) begin
            step();
            check_level("repeat_hold", {3'b000, (edge_cnt >= n + Lat)});
        end
        m = edge_cnt;
        btn_n_tb[0] = 1'b1;
        push_ev(m + Lat, KRelease, 0);
        for (int i = 0; i < 9; i++) begin
            step();
            check_level("repeat_release", {3'b000, (edge_cnt < m + Lat)});
        end
        drain("repeat");
    endtask

    task automatic test_release_glitch();
        int n, m;
        step();
        n = edge_cnt;
        btn_n_tb[2] = 1'b0;
        push_ev(n + Lat, KPress, 2);
        while (edge_cnt < n + Lat) step();
        btn_n_tb[2] = 1'b1;          // two-cycle release glitch
        repeat (2) begin
            step();
            check_level("glitch_high", 4'b0100);
        end
        btn_n_tb[2] = 1'b0;
        repeat (2) begin
            step();
            check_level("glitch_back", 4'b0100);
        end
        m = edge_cnt;
        btn_n_tb[2] = 1'b1;
        push_ev(m + Lat, KRelease, 2);
        for (int i = 0; i < 9; i++) begin
            step();
            check_level("glitch_release", {1'b0, (edge_cnt < m + Lat), 2'b00});
        end
        drain("release_glitch");
    endtask

    task automatic test_reset_mid();
        int n, e, m;
        step();
        n = edge_cnt;
        btn_n_tb[1] = 1'b0;
        push_ev(n + Lat, KPress, 1);
        while (edge_cnt < n + Lat + 4) step();
        check_level("mid_before_rst", 4'b0010);
        rst = 1'b1;
        #1;
        checks++;
        if ({bus.btn_level, bus.btn_press, bus.btn_release, bus.btn_repeat} !== '0) begin
            errors++;
            $display("FAIL reset_mid_immediate: got %h want 0",
                     {bus.btn_level, bus.btn_press, bus.btn_release, bus.btn_repeat});
        end
        repeat (2) step();
        e = edge_cnt;
        rst = 1'b0;
        push_ev(e + Lat, KPress, 1);
        for (int i = 0; i < 9; i++) begin
            step();
            check_level("mid_rerise", {2'b00, (edge_cnt >= e + Lat), 1'b0});
        end
        m = edge_cnt;
        btn_n_tb[1] = 1'b1;
        push_ev(m + Lat, KRelease, 1);
        for (int i = 0; i < 9; i++) begin
            step();
            check_level("mid_release", {2'b00, (edge_cnt < m + Lat), 1'b0});
        end
        drain("reset_mid");
    endtask

    task automatic test_simultaneous();
        int n, m;
        logic l;
        step();
        n = edge_cnt;
        btn_n_tb[0] = 1'b0;
        btn_n_tb[3] = 1'b0;
        push_ev(n + Lat, KPress, 0);
        push_ev(n + Lat, KPress, 3);
        for (int i = 0; i < 8; i++) begin
            step();
            l = (edge_cnt >= n + Lat);
            check_level("simul_press", {l, 2'b00, l});
        end
        m = edge_cnt;
        btn_n_tb[0] = 1'b1;
        btn_n_tb[3] = 1'b1;
        push_ev(m + Lat, KRelease, 0);
        push_ev(m + Lat, KRelease, 3);
        for (int i = 0; i < 9; i++) begin
            step();
            l = (edge_cnt < m + Lat);
            check_level("simul_release", {l, 2'b00, l});
        end
        drain("simultaneous");
    endtask

    initial begin
        rst = 1'b1;
        btn_n_tb = '1;
        test_reset();
        test_clean_press();
        test_bounce();
        test_repeat();
        test_release_glitch();
        test_reset_mid();
        test_simultaneous();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
